// File: rtl/serialize_scheduler.sv
// Round-robin word arbiter that serializes each granted word into DIVIDE_NUM slices.
// Define SERIALIZE_SCHED_MSB_FIRST_EN to emit the most-significant slice first.
module serialize_scheduler #(
  parameter  int DATA_WIDTH = 128,
  parameter  int DIVIDE_NUM = 4,
  parameter  int NUM_REQ    = 2,
  localparam int SLICE_W    = DATA_WIDTH / DIVIDE_NUM,
  localparam int SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic                          i_out_ready,
  output logic                          o_out_valid,
  output logic [SLICE_W-1:0]            o_out_data,
  output logic                          o_out_first,
  output logic                          o_out_last,
  output logic [SRC_W-1:0]              o_out_src,
  output logic                          o_busy
);

  localparam int CNT_W = (DIVIDE_NUM > 1) ? $clog2(DIVIDE_NUM) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDE_NUM - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SRC_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]        src_q, src_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;

  logic                    busy;
  logic                    out_fire;
  logic                    last_fire;
  logic                    accept_win;
  logic                    win_found;
  logic [SRC_W-1:0]        win_idx;
  logic [SRC_W-1:0]        win_cand;
  logic                    word_fire;
  logic [SLICE_W-1:0]      slice;

  assign busy      = (state_q == SEND);
  assign out_fire  = busy & i_out_ready;
  assign last_fire = out_fire & (cnt_q == LAST_CNT);
  // The grant window opens in IDLE or on the final slice handshake so words chain back-to-back.
  assign accept_win = i_rst_n & ((state_q == IDLE) | last_fire);

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      win_cand = SRC_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!win_found && i_req_valid[win_cand]) begin
        win_found = 1'b1;
        win_idx   = win_cand;
      end
    end
  end

  assign word_fire   = accept_win & win_found;
  assign o_req_ready = word_fire ? (NUM_REQ'(1) << win_idx) : '0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    src_d    = src_q;
    word_d   = word_q;
    if (out_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (last_fire) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
    if (word_fire) begin
      state_d  = SEND;
      cnt_d    = '0;
      src_d    = win_idx;
      word_d   = i_req_data[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
      rr_ptr_d = SRC_W'((32'(win_idx) + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      src_q    <= '0;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      src_q    <= src_d;
      word_q   <= word_d;
    end
  end

  always_comb begin
`ifdef SERIALIZE_SCHED_MSB_FIRST_EN
    slice = word_q[DATA_WIDTH-1-32'(cnt_q)*SLICE_W -: SLICE_W];
`else
    slice = word_q[32'(cnt_q)*SLICE_W +: SLICE_W];
`endif
  end

  assign o_busy      = busy;
  assign o_out_valid = busy;
  assign o_out_data  = busy ? slice : '0;
  assign o_out_first = busy & (cnt_q == '0);
  assign o_out_last  = busy & (cnt_q == LAST_CNT);
  assign o_out_src   = src_q;

endmodule

// File: tb/tb_serialize_scheduler.sv
// Bench for serialize_scheduler: directed scenarios plus random traffic against a slice-queue model.
module tb_serialize_scheduler;

  localparam int DW = 128;
  localparam int DN = 4;
  localparam int NR = 2;
  localparam int SW = DW / DN;
`ifdef SERIALIZE_SCHED_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_data;
  logic              out_ready;
  logic              out_valid;
  logic [SW-1:0]     out_data;
  logic              out_first;
  logic              out_last;
  logic [0:0]        out_src;
  logic              busy;

  serialize_scheduler #(
    .DATA_WIDTH (DW),
    .DIVIDE_NUM (DN),
    .NUM_REQ    (NR)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_data  (req_data),
    .i_out_ready (out_ready),
    .o_out_valid (out_valid),
    .o_out_data  (out_data),
    .o_out_first (out_first),
    .o_out_last  (out_last),
    .o_out_src   (out_src),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] d;
    bit            f;
    bit            l;
    int            src;
  } beat_t;

  beat_t q[$];
  int    rr;
  int    vectors = 0;
  int    miscompares = 0;

  localparam logic [DW-1:0] W0 = 128'h33333333_22222222_11111111_00000000;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called shortly after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    int      win;
    bit      acc;
    logic [NR-1:0] exp_ready;
    logic [DW-1:0] w;
    beat_t   b;
    #1;
    acc = (q.size() == 0) || (q.size() == 1 && out_ready);
    win = -1;
    for (int i = 0; i < NR; i++) begin
      int idx;
      idx = (rr + i) % NR;
      if (win < 0 && req_valid[idx]) win = idx;
    end
    exp_ready = (acc && win >= 0) ? NR'(1 << win) : '0;
    check_eq("req_ready", req_ready, exp_ready);
    check_eq("out_valid", out_valid, q.size() != 0);
    check_eq("busy", busy, q.size() != 0);
    if (q.size() != 0) begin
      check_eq("out_data", out_data, q[0].d);
      check_eq("out_first", out_first, q[0].f);
      check_eq("out_last", out_last, q[0].l);
      check_eq("out_src", out_src, q[0].src);
    end
    @(posedge clk);
    if (q.size() != 0 && out_ready) void'(q.pop_front());
    if (exp_ready != '0) begin
      w = req_data[win*DW +: DW];
      for (int n = 0; n < DN; n++) begin
        int sh;
        sh = MSB ? (DN - 1 - n) * SW : n * SW;
        b.d = SW'(w >> sh);
        b.f = (n == 0);
        b.l = (n == DN - 1);
        b.src = win;
        q.push_back(b);
      end
      rr = (win + 1) % NR;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_req_ready", req_ready, '0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, '0);
    check_eq("rst_out_first", out_first, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_out_src", out_src, 0);
    check_eq("rst_busy", busy, 0);
    q.delete();
    rr = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    rr = 0;
    @(negedge clk);
    req_valid = 2'b11;
    apply_reset();

    // Single word from requester 0, downstream always ready.
    req_valid = 2'b01;
    req_data  = {rand_word(), W0};
    out_ready = 1'b1;
    step();
    req_valid = 2'b00;
    for (int n = 0; n < DN; n++) begin
      #1;
      check_eq("beat_const", out_data, 32'h11111111 * (MSB ? 3 - n : n));
      step();
    end
    step();

    // Both requesters continuously valid: alternating grants with no gap.
    req_valid = 2'b11;
    for (int c = 0; c < 20; c++) begin
      req_data = {rand_word(), rand_word()};
      step();
    end
    req_valid = 2'b00;
    for (int c = 0; c < 5; c++) step();

    // Stall on slice 2 for three cycles while requester 1 waits.
    req_valid = 2'b01;
    req_data  = {rand_word(), W0};
    out_ready = 1'b1;
    step();
    req_valid = 2'b10;
    step();
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("stall_data", out_data, 32'h11111111 * (MSB ? 1 : 2));
      step();
    end
    out_ready = 1'b1;
    step();
    step();
    req_valid = 2'b00;
    for (int c = 0; c < 6; c++) step();

    // Reset while slice 1 is presented.
    req_valid = 2'b01;
    req_data  = {rand_word(), W0};
    step();
    req_valid = 2'b00;
    step();
    req_valid = 2'b11;
    apply_reset();
    for (int c = 0; c < 10; c++) step();

    // Random traffic with one mid-stream reset.
    for (int c = 0; c < 400; c++) begin
      req_valid = NR'($urandom_range(0, 3));
      req_data  = {rand_word(), rand_word()};
      out_ready = ($urandom_range(0, 3) != 0);
      if (c == 200) apply_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serialize_scheduler.md
SERIALIZE_SCHEDULER -- requirements
Module: serialize_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, width of each requester word.
REQ-002 SHALL have parameter DIVIDE_NUM, default 4, slices per word; DATA_WIDTH SHALL be an integer multiple of DIVIDE_NUM; SLICE_W = DATA_WIDTH/DIVIDE_NUM.
REQ-003 SHALL have parameter NUM_REQ, default 2, number of requesters (>=2); SRC_W = max(1, clog2(NUM_REQ)).
REQ-004 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_req_valid  input  NUM_REQ  per-requester word valid.
REQ-007 SHALL have port o_req_ready  output  NUM_REQ  per-requester accept, at most one bit set.
REQ-008 SHALL have port i_req_data  input  NUM_REQ*DATA_WIDTH  requester k word at [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port i_out_ready  input  1  downstream slice accept.
REQ-010 SHALL have port o_out_valid  output  1  slice valid.
REQ-011 SHALL have port o_out_data  output  SLICE_W  current slice.
REQ-012 SHALL have port o_out_first  output  1  high on slice 0 of a word.
REQ-013 SHALL have port o_out_last  output  1  high on slice DIVIDE_NUM-1 of a word.
REQ-014 SHALL have port o_out_src  output  SRC_W  index of requester owning current word.
REQ-015 SHALL have port o_busy  output  1  high while in SEND.

Function
REQ-016 SHALL implement FSM states IDLE and SEND.
REQ-017 Word transfer SHALL occur on i_req_valid[k] & o_req_ready[k]; slice transfer on o_out_valid & i_out_ready.
REQ-018 Grant SHALL be round-robin: search starts at rr_ptr, wraps NUM_REQ-1 -> 0; rr_ptr <= granted+1 (mod NUM_REQ) on each word transfer.
REQ-019 In IDLE, o_req_ready SHALL be one-hot on the arbitration winner when any i_req_valid is high, else all zero.
REQ-020 In SEND, o_req_ready SHALL be asserted to the winner only in the cycle of the last-slice transfer (back-to-back, zero idle cycles); otherwise zero.
REQ-021 On word transfer, word and source index SHALL be latched, slice counter cleared, state -> SEND; slice 0 SHALL appear on o_out_data the next cycle (latency 1).
REQ-022 In SEND, o_out_valid SHALL be 1; counter advances only on slice transfer; o_out_data/first/last/src SHALL hold stable while i_out_ready is low.
REQ-023 On last-slice transfer: if a new word transfers same cycle, stay in SEND with counter 0; else -> IDLE, o_out_valid 0 next cycle.
REQ-024 Requester dropping i_req_valid before grant SHALL have no effect; i_req_data of non-granted requesters SHALL be ignored.
REQ-025 o_req_ready SHALL depend combinationally only on state, counter, rr_ptr, i_req_valid and i_out_ready.

Reset
REQ-026 Assertion of i_rst_n low SHALL immediately force IDLE, rr_ptr 0, counter 0, o_out_valid/first/last/busy 0, o_out_data 0, o_out_src 0, o_req_ready 0.
REQ-027 Reset mid-word SHALL discard the in-flight word without emitting o_out_last; first grant after release SHALL favour requester 0.

Configuration
REQ-028 Macro SERIALIZE_SCHED_MSB_FIRST_EN defined: slice n SHALL be word bits [DATA_WIDTH-1-n*SLICE_W -: SLICE_W] (MSB slice first).
REQ-029 Macro undefined: slice n SHALL be word bits [n*SLICE_W +: SLICE_W] (LSB slice first); no other behaviour changes.

Verification (DATA_WIDTH=128, DIVIDE_NUM=4, NUM_REQ=2)
REQ-030 Req0 word 0x33333333_22222222_11111111_00000000, i_out_ready=1 -> next cycle 4 beats 0x00000000,0x11111111,0x22222222,0x33333333, first on beat0, last on beat3, src 0, then IDLE.
REQ-031 Both requesters valid continuously -> grants 0,1,0,1; o_out_valid high continuously, no gap cycles; src toggles at each first beat.
REQ-032 i_out_ready low for 3 cycles while slice 2 presented -> o_out_data stays 0x22222222, counter frozen, o_req_ready all 0 until beat3 transfers.
REQ-033 i_rst_n low during slice 1 -> outputs 0 in same cycle; after release with both valid, requester 0 granted first.
REQ-034 With SERIALIZE_SCHED_MSB_FIRST_EN, same word as REQ-030 -> beats 0x33333333,0x22222222,0x11111111,0x00000000.
